// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU command sequencer.
//   state_t  : sequencer FSM states
//   field_t  : which ALU input (A, B, opcode) is being loaded
//   BTN_*    : one-hot pulsador strobe patterns
//   DEF_*    : default widths and phase lengths
//   btn_of() : strobe pattern for a given field
package alu_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_GAP,
      S_SETTLE,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      F_A,
      F_B,
      F_OP
   } field_t;

   localparam logic [2:0] BTN_A  = 3'b001;
   localparam logic [2:0] BTN_B  = 3'b010;
   localparam logic [2:0] BTN_OP = 3'b100;

   localparam int DEF_NBITS      = 8;
   localparam int DEF_COD_OP     = 6;
   localparam int DEF_SETUP_CYC  = 10;
   localparam int DEF_PULSE_CYC  = 10;
   localparam int DEF_GAP_CYC    = 10;
   localparam int DEF_SETTLE_CYC = 2;
   localparam int DEF_CNT_W      = 8;

   function automatic logic [2:0] btn_of(input field_t f);
      return (f == F_A) ? BTN_A : (f == F_B) ? BTN_B : BTN_OP;
   endfunction

endpackage

// File: rtl/alu_cmd_sequencer_phase_timer.sv
// phase_timer: loadable down-counter that flags the last cycle of a phase.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_load      : load i_load_val (phase length minus one)
//   i_load_val  : value loaded on i_load
//   i_en        : count down while not yet at zero
//   o_expired   : high when the counter is zero, i.e. the final cycle of the phase
module phase_timer
   import alu_seq_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_expired
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (i_en && r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;
   end

   assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: drives the ALU top's switch/button interface to load A, B
// and the opcode with fixed setup/strobe/gap timing, then captures ALU_Out.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_start        : request, sampled only in IDLE
//   i_a_val/i_b_val: operands, latched on an accepted start
//   i_op_code      : opcode, latched on an accepted start
//   i_alu_result   : ALU top ALU_Out
//   o_entrada      : switch-bus value to the ALU top
//   o_pulsador     : one-hot load strobe (001=A, 010=B, 100=OP)
//   o_busy         : high from the cycle after accept through the last settle cycle
//   o_done         : one-cycle pulse, o_result valid
//   o_result       : captured ALU result, held until the next capture
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int NBITS      = DEF_NBITS,
   parameter int COD_OP     = DEF_COD_OP,
   parameter int SETUP_CYC  = DEF_SETUP_CYC,
   parameter int PULSE_CYC  = DEF_PULSE_CYC,
   parameter int GAP_CYC    = DEF_GAP_CYC,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [NBITS-1:0]  i_a_val,
   input  logic [NBITS-1:0]  i_b_val,
   input  logic [COD_OP-1:0] i_op_code,
   input  logic [NBITS-1:0]  i_alu_result,
   output logic [NBITS-1:0]  o_entrada,
   output logic [2:0]        o_pulsador,
   output logic              o_busy,
   output logic              o_done,
   output logic [NBITS-1:0]  o_result
);

   // Timer holds (length - 1) so that zero marks the last cycle of a phase.
   localparam logic [CNT_W-1:0] L_SETUP  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] L_PULSE  = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] L_GAP    = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] L_SETTLE = CNT_W'(SETTLE_CYC - 1);

   state_t              r_state;
   field_t              r_field;
   logic [NBITS-1:0]    r_a;
   logic [NBITS-1:0]    r_b;
   logic [COD_OP-1:0]   r_op;
   logic [NBITS-1:0]    r_entrada;
   logic [2:0]          r_pulsador;
   logic                r_busy;
   logic                r_done;
   logic [NBITS-1:0]    r_result;

   logic                w_timed;
   logic                w_expired;
   logic                w_load;
   logic [CNT_W-1:0]    w_load_val;

   assign w_timed = (r_state == S_SETUP) || (r_state == S_STROBE) ||
                    (r_state == S_GAP)   || (r_state == S_SETTLE);

   // Reload on every state entry: accept from IDLE or end of a timed phase.
   assign w_load = ((r_state == S_IDLE) && i_start) || (w_timed && w_expired);

   // Length of the phase being entered.
   always_comb begin
      w_load_val = '0;
      case (r_state)
         S_IDLE:   w_load_val = L_SETUP;
         S_SETUP:  w_load_val = L_PULSE;
         S_STROBE: w_load_val = L_GAP;
         S_GAP:    w_load_val = (r_field == F_OP) ? L_SETTLE : L_SETUP;
         default:  w_load_val = '0;
      endcase
   end

   phase_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_load),
      .i_load_val(w_load_val),
      .i_en      (w_timed),
      .o_expired (w_expired)
   );

   // entrada only changes on entry to SETUP (or back to 0 in IDLE), and
   // pulsador only on entry to/exit from STROBE, so they never move together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_field    <= F_A;
         r_a        <= '0;
         r_b        <= '0;
         r_op       <= '0;
         r_entrada  <= '0;
         r_pulsador <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_result   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_a       <= i_a_val;
                  r_b       <= i_b_val;
                  r_op      <= i_op_code;
                  r_field   <= F_A;
                  r_entrada <= i_a_val;
                  r_busy    <= 1'b1;
                  r_state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (w_expired) begin
                  r_pulsador <= btn_of(r_field);
                  r_state    <= S_STROBE;
               end
            end
            S_STROBE: begin
               if (w_expired) begin
                  r_pulsador <= '0;
                  r_state    <= S_GAP;
               end
            end
            S_GAP: begin
               if (w_expired) begin
                  if (r_field == F_OP) begin
                     r_state <= S_SETTLE;
                  end else begin
                     r_field   <= (r_field == F_A) ? F_B : F_OP;
                     r_entrada <= (r_field == F_A) ? r_b : NBITS'(r_op);
                     r_state   <= S_SETUP;
                  end
               end
            end
            S_SETTLE: begin
               if (w_expired) begin
                  r_result <= i_alu_result;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_done    <= 1'b0;
               r_entrada <= '0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_entrada  = r_entrada;
   assign o_pulsador = r_pulsador;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_result   = r_result;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: bench for alu_cmd_sequencer with a behavioural ALU top
// behind it; default-timing instance plus an all-ones-timing instance.
module tb_alu_cmd_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h03:   return 8'($signed(a) >>> b);
         6'h02:   return a >> b;
         6'h27:   return ~(a | b);
         default: return 8'h00;
      endcase
   endfunction

   // default-timing DUT
   logic       i_start = 1'b0;
   logic [7:0] i_a = '0, i_b = '0;
   logic [5:0] i_op = '0;
   logic [7:0] alu_out, o_entrada, o_result;
   logic [2:0] o_pulsador;
   logic       o_busy, o_done;
   logic [7:0] alu_a = '0, alu_b = '0, alu_op = '0;

   alu_cmd_sequencer dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_a_val(i_a), .i_b_val(i_b),
      .i_op_code(i_op), .i_alu_result(alu_out), .o_entrada(o_entrada),
      .o_pulsador(o_pulsador), .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
   );

   always_ff @(posedge clk) begin
      if (o_pulsador[0]) alu_a <= o_entrada;
      if (o_pulsador[1]) alu_b <= o_entrada;
      if (o_pulsador[2]) alu_op <= o_entrada;
   end
   assign alu_out = alu_f(alu_a, alu_b, alu_op[5:0]);

   // minimal-timing DUT
   logic       m_start = 1'b0;
   logic [7:0] m_a = '0, m_b = '0;
   logic [5:0] m_op = '0;
   logic [7:0] m_alu, m_ent, m_res;
   logic [2:0] m_pul;
   logic       m_busy, m_done;
   logic [7:0] ma = '0, mb = '0, mop = '0;

   alu_cmd_sequencer #(
      .SETUP_CYC(1), .PULSE_CYC(1), .GAP_CYC(1), .SETTLE_CYC(1)
   ) dut_min (
      .clk(clk), .rst_n(rst_n), .i_start(m_start), .i_a_val(m_a), .i_b_val(m_b),
      .i_op_code(m_op), .i_alu_result(m_alu), .o_entrada(m_ent),
      .o_pulsador(m_pul), .o_busy(m_busy), .o_done(m_done), .o_result(m_res)
   );

   always_ff @(posedge clk) begin
      if (m_pul[0]) ma <= m_ent;
      if (m_pul[1]) mb <= m_ent;
      if (m_pul[2]) mop <= m_ent;
   end
   assign m_alu = alu_f(ma, mb, mop[5:0]);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: plain; 1: scramble inputs every cycle; 2: extra start pulses in A STROBE and DONE
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                         input logic [7:0] exp, input int mode, input string nm);
      int done_cyc = 0, n_done = 0, ent_bad = 0, hot_bad = 0, busy_after = 0, busy_bad = 0;
      int p_cnt[3] = '{0, 0, 0};
      logic [7:0] fv[3];
      fv[0] = a;
      fv[1] = b;
      fv[2] = {2'b00, op};
      i_a = a;
      i_b = b;
      i_op = op;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int c = 1; c <= 130; c++) begin
         if (mode == 1) begin
            i_a = 8'($urandom);
            i_b = 8'($urandom);
            i_op = 6'($urandom);
         end
         if (mode == 2) i_start = (c == 15) || (c == 93);
         if ((o_pulsador & (o_pulsador - 3'd1)) != 3'd0) hot_bad++;
         for (int f = 0; f < 3; f++)
            if (o_pulsador[f]) begin
               p_cnt[f]++;
               if (o_entrada != fv[f]) ent_bad++;
            end
         if (o_done) begin
            n_done++;
            if (done_cyc == 0) begin
               done_cyc = c;
               chk({nm, "_result"}, o_result, exp);
               chk({nm, "_busy_at_done"}, o_busy, 0);
            end
         end
         if (done_cyc != 0 && c > done_cyc && o_busy) busy_after++;
         if (c < 93 && !o_busy) busy_bad++;
         tick();
      end
      i_start = 1'b0;
      chk({nm, "_done_cycle"}, done_cyc, 93);
      chk({nm, "_done_count"}, n_done, 1);
      chk({nm, "_strobe_a_len"}, p_cnt[0], 10);
      chk({nm, "_strobe_b_len"}, p_cnt[1], 10);
      chk({nm, "_strobe_op_len"}, p_cnt[2], 10);
      chk({nm, "_entrada_in_strobe"}, ent_bad, 0);
      chk({nm, "_onehot"}, hot_bad, 0);
      chk({nm, "_busy_low_early"}, busy_bad, 0);
      chk({nm, "_busy_after_done"}, busy_after, 0);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [5:0] op;
      logic [7:0] exp;
      int         mode;
      string      nm;
   } vec_t;

   vec_t vt[11];

   initial begin
      int d1, d2, ba, mdone, mbad, mstab, nstr;
      logic [7:0] ent_h[0:20];
      logic [2:0] pul_h[0:20];

      vt = '{
         '{8'h04, 8'h05, 6'h20, 8'h09, 0, "add"},
         '{8'h09, 8'h02, 6'h22, 8'h07, 0, "sub"},
         '{8'h02, 8'h09, 6'h22, 8'hF9, 0, "sub_wrap"},
         '{8'hF0, 8'h3C, 6'h24, 8'h30, 0, "and"},
         '{8'hF0, 8'h0F, 6'h25, 8'hFF, 0, "or"},
         '{8'hAA, 8'hFF, 6'h26, 8'h55, 0, "xor"},
         '{8'h80, 8'h02, 6'h03, 8'hE0, 0, "sra"},
         '{8'h80, 8'h02, 6'h02, 8'h20, 0, "srl"},
         '{8'hFF, 8'h01, 6'h20, 8'h00, 0, "add_wrap"},
         '{8'h04, 8'h05, 6'h20, 8'h09, 1, "scramble"},
         '{8'h04, 8'h05, 6'h20, 8'h09, 2, "start_ignored"}
      };

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", {o_entrada, o_pulsador, o_busy, o_done, o_result}, 0);
      chk("rst_outputs_min", {m_ent, m_pul, m_busy, m_done, m_res}, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", o_busy, 0);

      for (int v = 0; v < 11; v++)
         run_op(vt[v].a, vt[v].b, vt[v].op, vt[v].exp, vt[v].mode, vt[v].nm);

      // back-to-back with start held: ADD then SUB
      d1 = 0;
      d2 = 0;
      ba = 0;
      i_a = 8'h09;
      i_b = 8'h02;
      i_op = 6'h20;
      i_start = 1'b1;
      tick();
      for (int c = 1; c <= 200; c++) begin
         if (o_done && d1 == 0) begin
            d1 = c;
            chk("b2b_add_result", o_result, 8'h0B);
            i_op = 6'h22;
         end else if (o_done && d2 == 0) begin
            d2 = c;
            chk("b2b_sub_result", o_result, 8'h07);
            i_start = 1'b0;
         end
         if (d1 != 0 && c == d1 + 1) chk("b2b_idle_busy", o_busy, 0);
         if (d1 != 0 && c == d1 + 2) begin
            chk("b2b_setup_busy", o_busy, 1);
            chk("b2b_setup_entrada", o_entrada, 8'h09);
         end
         if (d2 != 0 && c > d2 && o_busy) ba++;
         tick();
      end
      i_start = 1'b0;
      chk("b2b_done1_cycle", d1, 93);
      chk("b2b_done2_cycle", d2, 187);
      chk("b2b_no_third", ba, 0);

      // async reset in the middle of the B strobe
      i_a = 8'h04;
      i_b = 8'h05;
      i_op = 6'h20;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int c = 1; c < 45; c++) tick();
      chk("midrst_pre_pulsador", o_pulsador, 3'b010);
      chk("midrst_pre_entrada", o_entrada, 8'h05);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_pulsador", o_pulsador, 0);
      chk("midrst_entrada", o_entrada, 0);
      chk("midrst_busy", o_busy, 0);
      chk("midrst_result", o_result, 0);
      tick();
      rst_n = 1'b1;
      tick();
      run_op(8'h09, 8'h02, 6'h27, 8'hF4, 0, "nor_after_rst");

      // minimal timing
      mdone = 0;
      mbad = 0;
      mstab = 0;
      nstr = 0;
      m_a = 8'h04;
      m_b = 8'h05;
      m_op = 6'h20;
      ent_h[0] = m_ent;
      pul_h[0] = m_pul;
      m_start = 1'b1;
      tick();
      m_start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         ent_h[c] = m_ent;
         pul_h[c] = m_pul;
         if ((m_pul & (m_pul - 3'd1)) != 3'd0) mbad++;
         if (m_done && mdone == 0) begin
            mdone = c;
            chk("min_result", m_res, 8'h09);
         end
         tick();
      end
      for (int c = 1; c < 20; c++)
         if (pul_h[c] != 3'd0) begin
            nstr++;
            if (ent_h[c-1] != ent_h[c] || ent_h[c+1] != ent_h[c]) mstab++;
         end
      chk("min_done_cycle", mdone, 11);
      chk("min_onehot", mbad, 0);
      chk("min_entrada_stable", mstab, 0);
      chk("min_strobe_count", nstr, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
